// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the 640x480@60 raster: default porch/sync widths,
// derived totals and sync windows, plus coordinate and RGB332 widths.
package vga_timing_pkg;

  localparam int COORD_W = 10;
  localparam int RGB_W   = 8;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Sync pulse occupies [active+fp, active+fp+sync-1] on either axis.
  function automatic int sync_first(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_last(input int active, input int fp, input int sync);
    return active + fp + sync - 1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with enable, terminal count, and decodes of the
// active region and the sync window for the current count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = DEF_H_TOTAL,
  parameter int ACTIVE     = DEF_H_ACTIVE,
  parameter int SYNC_START = DEF_H_ACTIVE + DEF_H_FP,
  parameter int SYNC_END   = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC - 1
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  output logic [COORD_W-1:0] o_cnt,
  output logic               o_tc,
  output logic               o_active,
  output logic               o_sync
);

  logic [COORD_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + COORD_W'(1);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_tc     = (r_cnt == COORD_W'(TOTAL - 1));
  assign o_active = (r_cnt < COORD_W'(ACTIVE));
  assign o_sync   = (r_cnt >= COORD_W'(SYNC_START)) && (r_cnt <= COORD_W'(SYNC_END));

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing controller: issues pixel fetches and drives sync/RGB332 to the DAC.
// Define VGA_PIX_DIV2_EN for a 2-clk pixel slot (50 MHz clk, 25 MHz pixel rate).
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [RGB_W-1:0]   next_color,
  output logic               req,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               hsync,
  output logic               vsync,
  output logic [RGB_W-1:0]   rgb,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic               w_slot_start;
  logic [COORD_W-1:0] w_h_cnt;
  logic [COORD_W-1:0] w_v_cnt;
  logic               w_h_tc;
  logic               w_v_tc;
  logic               w_h_act;
  logic               w_v_act;
  logic               w_h_sync;
  logic               w_v_sync;

  logic r_origin;
  logic r_act_d0;
  logic r_hs_d0;
  logic r_vs_d0;
  logic r_act_d1;
  logic r_hs_d1;
  logic r_vs_d1;

`ifdef VGA_PIX_DIV2_EN
  logic r_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= 1'b0;
    end else begin
      r_phase <= ~r_phase;
    end
  end

  assign w_slot_start = ~r_phase;
`else
  assign w_slot_start = 1'b1;
`endif

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (sync_first(H_ACTIVE, H_FP)),
    .SYNC_END   (sync_last(H_ACTIVE, H_FP, H_SYNC))
  ) u_h_axis (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_slot_start),
    .o_cnt    (w_h_cnt),
    .o_tc     (w_h_tc),
    .o_active (w_h_act),
    .o_sync   (w_h_sync)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (sync_first(V_ACTIVE, V_FP)),
    .SYNC_END   (sync_last(V_ACTIVE, V_FP, V_SYNC))
  ) u_v_axis (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_slot_start & w_h_tc),
    .o_cnt    (w_v_cnt),
    .o_tc     (w_v_tc),
    .o_active (w_v_act),
    .o_sync   (w_v_sync)
  );

  // The counters run one slot ahead of col/row; stage d0 is aligned with col/row,
  // d1 one clk later, and the DAC registers two clk after col/row show a position.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_origin    <= 1'b1;
      req         <= 1'b0;
      col         <= '0;
      row         <= '0;
      frame_start <= 1'b0;
      r_act_d0    <= 1'b0;
      r_hs_d0     <= 1'b0;
      r_vs_d0     <= 1'b0;
      r_act_d1    <= 1'b0;
      r_hs_d1     <= 1'b0;
      r_vs_d1     <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb         <= '0;
    end else begin
      req         <= w_slot_start & w_h_act & w_v_act;
      frame_start <= w_slot_start & r_origin;
      if (w_slot_start) begin
        r_origin <= w_h_tc & w_v_tc;
        col      <= w_h_cnt;
        row      <= w_v_cnt;
        r_act_d0 <= w_h_act & w_v_act;
        r_hs_d0  <= w_h_sync;
        r_vs_d0  <= w_v_sync;
      end
      r_act_d1 <= r_act_d0;
      r_hs_d1  <= r_hs_d0;
      r_vs_d1  <= r_vs_d0;
      rgb      <= r_act_d1 ? next_color : '0;
      hsync    <= ~r_hs_d1;
      vsync    <= ~r_vs_d1;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a full-size instance for line timing and a shrunken
// raster instance for frame timing, each with an echo pixel generator.
module tb_vga_timing_ctrl;

`ifdef VGA_PIX_DIV2_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  localparam logic [9:0] RST_OUT = 10'b11_0000_0000;

  // Shrunken raster for instance 1: 32 x 19 totals.
  localparam int SM_HA = 16, SM_HF = 4, SM_HS = 6, SM_HB = 6;
  localparam int SM_VA = 12, SM_VF = 2, SM_VS = 2, SM_VB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0] nc0 = '0, nc1 = '0;
  logic       req0, req1, hs0, hs1, vs0, vs1, fs0, fs1;
  logic [9:0] col0, col1, row0, row1;
  logic [7:0] rgb0, rgb1;

  int n_vec = 0;
  int n_err = 0;
  int t_clk = -1;
  int n_edges = 0;

  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];

  logic [9:0] e_col, e_row, e_out;
  logic       e_req, e_fs;

  logic meas_en = 1'b0;
  logic post_en = 1'b0;
  int req0_cnt = 0, hs0_low = 0, hs0_first = -1, line0_len = -1;
  int req1_cnt = 0, vs1_low = 0, fs1_n = 0, fs1_second = -1;
  int first_req_t = -1;
  logic [9:0] first_req_col = '0, first_req_row = '0;

  always #5 clk = ~clk;

  vga_timing_ctrl u_dut_std (
    .clk         (clk),
    .rst         (rst),
    .next_color  (nc0),
    .req         (req0),
    .col         (col0),
    .row         (row0),
    .hsync       (hs0),
    .vsync       (vs0),
    .rgb         (rgb0),
    .frame_start (fs0)
  );

  vga_timing_ctrl #(
    .H_ACTIVE (SM_HA), .H_FP (SM_HF), .H_SYNC (SM_HS), .H_BP (SM_HB),
    .V_ACTIVE (SM_VA), .V_FP (SM_VF), .V_SYNC (SM_VS), .V_BP (SM_VB)
  ) u_dut_small (
    .clk         (clk),
    .rst         (rst),
    .next_color  (nc1),
    .req         (req1),
    .col         (col1),
    .row         (row1),
    .hsync       (hs1),
    .vsync       (vs1),
    .rgb         (rgb1),
    .frame_start (fs1)
  );

  // Registered echo pixel generator: reply captured on the edge that ends req.
  always @(posedge clk) begin
    if (req0) nc0 <= {col0[2:0], row0[2:0], 2'b01};
    if (req1) nc1 <= {col1[2:0], row1[2:0], 2'b01};
  end

  always @(posedge clk) begin
    n_edges <= n_edges + 1;
    t_clk   <= rst ? -1 : t_clk + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t_clk, got, exp);
    end
  endtask

  // Reference raster: position, request and delayed-output expectation at clk t.
  task automatic exp_at(input int id, input int t, output logic [9:0] o_col,
                        output logic [9:0] o_row, output logic o_req,
                        output logic o_fs, output logic [9:0] o_out);
    int ha, hf, hsw, hb, va, vf, vsw, vb, ht, vt, slot, ph, pos, h, v;
    logic act, hsn, vsn;
    if (id == 0) begin
      ha = 640; hf = 16; hsw = 96; hb = 48; va = 480; vf = 10; vsw = 2; vb = 33;
    end else begin
      ha = SM_HA; hf = SM_HF; hsw = SM_HS; hb = SM_HB;
      va = SM_VA; vf = SM_VF; vsw = SM_VS; vb = SM_VB;
    end
    ht   = ha + hf + hsw + hb;
    vt   = va + vf + vsw + vb;
    slot = t / S;
    ph   = t % S;
    pos  = slot % (ht * vt);
    h    = pos % ht;
    v    = pos / ht;
    act  = (h < ha) && (v < va);
    hsn  = !((h >= ha + hf) && (h <= ha + hf + hsw - 1));
    vsn  = !((v >= va + vf) && (v <= va + vf + vsw - 1));
    o_col = 10'(h);
    o_row = 10'(v);
    o_req = (ph == 0) && act;
    o_fs  = (ph == 0) && (pos == 0);
    o_out = {hsn, vsn, act ? {3'(h), 3'(v), 2'b01} : 8'h00};
  endtask

  always @(negedge clk) begin
    if (n_edges > 0) begin
      if (t_clk < 0) begin
        exp_q0.delete(); exp_q0.push_back(RST_OUT); exp_q0.push_back(RST_OUT);
        exp_q1.delete(); exp_q1.push_back(RST_OUT); exp_q1.push_back(RST_OUT);
        chk("rst_col0", col0, 0);
        chk("rst_row0", row0, 0);
        chk("rst_req0", req0, 0);
        chk("rst_fs0", fs0, 0);
        chk("rst_out0", {hs0, vs0, rgb0}, RST_OUT);
        chk("rst_col1", col1, 0);
        chk("rst_row1", row1, 0);
        chk("rst_req1", req1, 0);
        chk("rst_fs1", fs1, 0);
        chk("rst_out1", {hs1, vs1, rgb1}, RST_OUT);
      end else begin
        exp_at(0, t_clk, e_col, e_row, e_req, e_fs, e_out);
        chk("col0", col0, e_col);
        chk("row0", row0, e_row);
        chk("req0", req0, e_req);
        chk("fs0", fs0, e_fs);
        exp_q0.push_back(e_out);
        chk("out0", {hs0, vs0, rgb0}, exp_q0.pop_front());

        exp_at(1, t_clk, e_col, e_row, e_req, e_fs, e_out);
        chk("col1", col1, e_col);
        chk("row1", row1, e_row);
        chk("req1", req1, e_req);
        chk("fs1", fs1, e_fs);
        exp_q1.push_back(e_out);
        chk("out1", {hs1, vs1, rgb1}, exp_q1.pop_front());

        if (meas_en) begin
          if (t_clk < 800 * S && req0) req0_cnt++;
          if (t_clk >= 2 && t_clk < 800 * S + 2 && !hs0) hs0_low++;
          if (hs0_first < 0 && !hs0) hs0_first = t_clk;
          if (line0_len < 0 && col0 == 10'd0 && row0 == 10'd1) line0_len = t_clk;
          if (t_clk < 608 * S && req1) req1_cnt++;
          if (t_clk >= 2 && t_clk < 608 * S + 2 && !vs1) vs1_low++;
          if (fs1) begin
            fs1_n++;
            if (fs1_n == 2) fs1_second = t_clk;
          end
        end
        if (post_en && first_req_t < 0 && req0) begin
          first_req_t   = t_clk;
          first_req_col = col0;
          first_req_row = row0;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    meas_en = 1'b1;
    repeat (820 * S) @(negedge clk);
    meas_en = 1'b0;

    chk("line_req_cnt", req0_cnt, 640);
    chk("line_hs_low", hs0_low, 96 * S);
    chk("line_hs_first", hs0_first, 656 * S + 2);
    chk("line_len", line0_len, 800 * S);
    chk("frame_req_cnt", req1_cnt, SM_HA * SM_VA);
    chk("frame_vs_low", vs1_low, SM_VS * 32 * S);
    chk("frame_period", fs1_second, 32 * 19 * S);

    repeat ($urandom_range(1, 60)) @(negedge clk);
    rst = 1'b1;
    repeat ($urandom_range(1, 2)) @(negedge clk);
    rst = 1'b0;
    post_en = 1'b1;
    repeat (50 * S) @(negedge clk);
    chk("rerst_req_t", first_req_t, 0);
    chk("rerst_req_col", first_req_col, 0);
    chk("rerst_req_row", first_req_row, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Raster timing controller for the 640x480@60 Hz VGA output path. It is the requesting end of the pixel-fetch interface: it scans the raster, issues `req` with `col`/`row` to the pixel generator, and consumes the registered `next_color` reply. It also drives `hsync`, `vsync` and 8-bit RGB332 to the DAC pins, with fetched data and sync aligned.

## Interface
Parameters:
- `H_ACTIVE` 640; `H_FP` 16; `H_SYNC` 96; `H_BP` 48: horizontal timing in pixels. `H_TOTAL` = 800.
- `V_ACTIVE` 480; `V_FP` 10; `V_SYNC` 2; `V_BP` 33: vertical timing in lines. `V_TOTAL` = 525.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `next_color` in 8: pixel generator reply, RGB332. Valid from the clk after a `req` cycle, held until the next `req`.
- `req` out 1: fetch strobe, one clk per active pixel slot.
- `col` out 10: fetch column (horizontal counter, 0..H_TOTAL-1).
- `row` out 10: fetch row (vertical counter, 0..V_TOTAL-1).
- `hsync` out 1: horizontal sync, active low.
- `vsync` out 1: vertical sync, active low.
- `rgb` out 8: pixel to the DAC. Forced to 0 during blanking.
- `frame_start` out 1: one-clk pulse when the fetch position becomes (0,0).

## Operation
- **Pixel slot.** A slot is 1 clk by default, or 2 clk with `VGA_PIX_DIV2_EN` (see Configuration). A slot-phase counter marks the first clk of each slot.
- **Counters.** `h_cnt` increments at each slot start. At H_TOTAL-1 it wraps to 0 and `v_cnt` increments. `v_cnt` wraps from V_TOTAL-1 to 0 on the same edge that `h_cnt` wraps.
- **Fetch outputs.** `col`/`row` are registered copies of `h_cnt`/`v_cnt` and are stable for the whole slot.
- **Active region.** `active` = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- **Request.** `req` = 1 only in the first clk of a slot, and only when that slot is active. No `req` is issued during blanking.
- **Sync decode.**
  - `hsync` = 0 when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - `vsync` = 0 when v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
- **Output pipeline.** `active`, hsync-decode and vsync-decode pass through a 2-clk delay line. At stage 2, `rgb` <= delayed active ? `next_color` : 0, and `hsync`/`vsync` <= the delayed decodes.
- **Reset values.** `req`=0, `col`=0, `row`=0, `hsync`=1, `vsync`=1, `rgb`=0, `frame_start`=0. Counters, slot phase and delay lines are cleared.
- **Reset mid-frame.** All state returns to reset values on the next edge. The raster restarts at (0,0) on the first edge after `rst` falls, and `frame_start` pulses then.

## Timing
- **Fetch/capture.** `col`/`row`/`req` change on a slot-start edge. The pixel generator captures on the edge that ends the `req` clk.
- **Latency.** `rgb`, `hsync` and `vsync` for position P appear exactly 2 clk after `col`/`row` first show P, in both slot modes.
- **Throughput.**
  - 1-clk slot: `req` is held high continuously across each active line (640 clk).
  - 2-clk slot: `req` toggles 1,0 across the line.
- **Frame length.** H_TOTAL*V_TOTAL slots; `frame_start` recurs every 420000 slots.
- **Simultaneous wraps.** At (799,524) -> (0,0), h and v wrap on the same edge and `frame_start` pulses on that edge's output.
- **Blanked edges.** Zero-time blank at line end: `rgb` is 0 for all delayed positions with h >= 640 or v >= 480.

## Configuration
- `VGA_PIX_DIV2_EN` defined:
  - Slot = 2 clk, for a 50 MHz `clk` driving a 25 MHz pixel rate.
  - The slot-phase bit toggles every clk; `req` is high only in phase 0.
- Undefined:
  - Slot = 1 clk, for a `clk` that already runs at 25 MHz.
  - No phase register; every clk is a slot start.

## Structure
- Shared package `vga_timing_pkg`:
  - Default timing constants, H_TOTAL/V_TOTAL and the sync start/end derivations.
  - RGB332 width constant (8) and the 10-bit coordinate width.
- One sub-module, `vga_axis_counter`: a parameterised wrap counter with enable, terminal-count output and sync-window decode. It is instantiated once for horizontal and once for vertical (enabled by the horizontal terminal count).

## Test plan
- **Reset.** Hold `rst` 5 clk -> `hsync`=`vsync`=1, `rgb`=0, `req`=0, `col`=`row`=0. `frame_start`=1 on the first edge after release.
- **Echo responder.** Bench returns `next_color`={col[2:0],row[2:0],2'b01} one clk after `req` -> every active `rgb` equals the value for the position shown 2 clk earlier, and `rgb`=0 for h>=640.
- **Line timing.** Count clk in 1-clk mode -> line = 800 clk, `hsync` low for exactly 96 clk starting 656+2 clk after col=0, `req` high for 640 clk per active line.
- **Frame timing.** Run one frame -> `vsync` low for 2 lines (1600 clk), `req` count = 307200, `frame_start` period = 420000 clk.
- **Div2 mode.** Define `VGA_PIX_DIV2_EN` -> line = 1600 clk, `req` pattern 1,0 per slot, `rgb` latency still 2 clk.
- **Mid-frame reset.** Assert `rst` at (300,200) for 1 clk -> outputs return to reset values next edge, and the next `req` occurs at col=0,row=0.
